// File: rtl/bayer_timing_ctrl.sv
// bayer_timing_ctrl
// Sequencing controller for the OV5640 capture path. Registers the raw camera
// vsync/hsync, tracks pixel and line position, drops start-up frames, drives
// the Bayer phase (mode) and the gated frame/pixel strobes, and reports the
// measured frame size plus width/height errors at each frame close.
//
// Optional build macro: BAYER_TIMING_CTRL_STATS_EN
//   When defined, adds frame_count (wrapping) and err_count (saturating)
//   outputs. Without it those ports and counters do not exist.

module bayer_timing_ctrl #(
    parameter int         VIDEO_WIDTH  = 1280,
    parameter int         VIDEO_HEIGHT = 720,
    parameter int         CNT_WIDTH    = 12,
    parameter logic [1:0] BAYER_START  = 2'b00,
    parameter int         SKIP_FRAMES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vsync,
    input  logic                 in_hsync,
    output logic [1:0]           mode,
    output logic                 out_vsync,
    output logic                 out_pix_valid,
    output logic                 frame_active,
    output logic                 frame_done,
    output logic [CNT_WIDTH-1:0] meas_width,
    output logic [CNT_WIDTH-1:0] meas_height,
    output logic                 err_width,
    output logic                 err_height
`ifdef BAYER_TIMING_CTRL_STATS_EN
    ,
    output logic [15:0]          frame_count,
    output logic [15:0]          err_count
`endif
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_SKIP = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] W_C     = CNT_WIDTH'(VIDEO_WIDTH);
    localparam logic [CNT_WIDTH-1:0] H_C     = CNT_WIDTH'(VIDEO_HEIGHT);
    localparam logic [3:0]           SKIP_C  = 4'(SKIP_FRAMES);

    // Saturating increment used by the pixel and line counters.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
    endfunction

    // ------------------------------------------------------------------
    // Input stage: one register for use, a second copy for edge detection
    // (vs_s1_q/hs_s1_q are the registered inputs, *_s2_q the delayed copy).
    // ------------------------------------------------------------------
    logic vs_s1_q, vs_s2_q;
    logic hs_s1_q, hs_s2_q;
    logic vs_rise, hs_fall;

    // Register the camera syncs twice.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of its source, independent of order.
        if (rst) begin
            vs_s1_q <= 1'b0;
            vs_s2_q <= 1'b0;
            hs_s1_q <= 1'b0;
            hs_s2_q <= 1'b0;
        end else begin
            vs_s1_q <= in_vsync;
            vs_s2_q <= vs_s1_q;
            hs_s1_q <= in_hsync;
            hs_s2_q <= hs_s1_q;
        end
    end

    assign vs_rise = vs_s1_q & ~vs_s2_q;
    assign hs_fall = ~hs_s1_q & hs_s2_q;

    // ------------------------------------------------------------------
    // Frame sequencing FSM: SYNC -> SKIP (optional) -> RUN
    // ------------------------------------------------------------------
    logic [1:0] state_q, state_d;
    logic [3:0] skip_q, skip_d;
    logic       go_run;

    // Next-state logic; go_run flags the vs_rise that enters RUN.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        skip_d  = skip_q;
        go_run  = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (vs_rise) begin
                    if (SKIP_C == 4'd0) begin
                        state_d = ST_RUN;
                        go_run  = 1'b1;
                    end else begin
                        state_d = ST_SKIP;
                    end
                end
            end
            ST_SKIP: begin
                if (vs_rise) begin
                    skip_d = skip_q + 4'd1;
                    if (skip_d == SKIP_C) begin
                        state_d = ST_RUN;
                        go_run  = 1'b1;
                    end
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_SYNC;
        endcase
    end

    // FSM state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SYNC;
            skip_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end
    end

    logic run;
    logic frame_start;
    logic frame_close;
    logic frame_active_q;

    assign run         = (state_q == ST_RUN);
    // The vs_rise that enters RUN already counts as a RUN frame start.
    assign frame_start = vs_rise & (run | go_run);
    assign frame_close = frame_start & frame_active_q;

    // ------------------------------------------------------------------
    // Pixel / line position tracking (runs in every state)
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] pix_q, pix_d;
    logic [CNT_WIDTH-1:0] line_q, line_d;
    logic [CNT_WIDTH-1:0] last_len_q, last_len_d;
    logic                 err_w_q, err_w_d;
    // trunc_q marks the tail of a line cut by vsync: its falling edge must
    // not be counted as a line of the new frame.
    logic                 trunc_q, trunc_d;
    logic                 line_done;

    assign line_done = hs_fall & ~trunc_q;

    // Counter next-state: vs_rise takes priority over line bookkeeping.
    always_comb begin
        pix_d      = pix_q;
        line_d     = line_q;
        last_len_d = last_len_q;
        err_w_d    = err_w_q;
        trunc_d    = trunc_q;

        if (hs_fall) begin
            pix_d   = '0;
            trunc_d = 1'b0;
            if (!trunc_q) begin
                line_d     = sat_inc(line_q);
                last_len_d = pix_q;
                if (pix_q != W_C) begin
                    err_w_d = 1'b1;
                end
            end
        end else if (hs_s1_q) begin
            pix_d = sat_inc(pix_q);
        end

        if (vs_rise) begin
            line_d  = '0;
            err_w_d = 1'b0;
            if (hs_s1_q) begin
                pix_d   = '0;
                trunc_d = 1'b1;
            end
        end
    end

    // Position counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q      <= '0;
            line_q     <= '0;
            last_len_q <= '0;
            err_w_q    <= 1'b0;
            trunc_q    <= 1'b0;
        end else begin
            pix_q      <= pix_d;
            line_q     <= line_d;
            last_len_q <= last_len_d;
            err_w_q    <= err_w_d;
            trunc_q    <= trunc_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame-close status: a line ending (or being truncated) in the same
    // cycle as vs_rise still belongs to the closing frame.
    // ------------------------------------------------------------------
    logic                 close_line;
    logic [CNT_WIDTH-1:0] close_h;
    logic [CNT_WIDTH-1:0] close_w;
    logic                 close_ew;
    logic                 close_eh;

    // Values latched into the meas_*/err_* outputs at frame close.
    always_comb begin
        close_line = line_done | hs_s1_q;
        close_h    = close_line ? sat_inc(line_q) : line_q;
        close_w    = close_line ? pix_q : last_len_q;
        close_ew   = err_w_q | (close_line & (pix_q != W_C));
        close_eh   = (close_h != H_C);
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [1:0]           mode_q;
    logic                 out_vsync_q;
    logic                 out_pix_valid_q;
    logic                 frame_done_q;
    logic [CNT_WIDTH-1:0] meas_width_q;
    logic [CNT_WIDTH-1:0] meas_height_q;
    logic                 err_width_q;
    logic                 err_height_q;

    // Strobes gated by RUN, Bayer phase, and status latched at frame close.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q          <= 2'b00;
            out_vsync_q     <= 1'b0;
            out_pix_valid_q <= 1'b0;
            frame_active_q  <= 1'b0;
            frame_done_q    <= 1'b0;
            meas_width_q    <= '0;
            meas_height_q   <= '0;
            err_width_q     <= 1'b0;
            err_height_q    <= 1'b0;
        end else begin
            out_vsync_q     <= frame_start;
            frame_done_q    <= frame_close;
            out_pix_valid_q <= hs_s1_q & run;
            if (frame_start) begin
                frame_active_q <= 1'b1;
            end
            // Phase of the pixel currently in hs_s1_q; holds between lines.
            if (hs_s1_q & run) begin
                mode_q <= {line_q[0] ^ BAYER_START[1], pix_q[0] ^ BAYER_START[0]};
            end
            if (frame_close) begin
                meas_width_q  <= close_w;
                meas_height_q <= close_h;
                err_width_q   <= close_ew;
                err_height_q  <= close_eh;
            end
        end
    end

    assign mode          = mode_q;
    assign out_vsync     = out_vsync_q;
    assign out_pix_valid = out_pix_valid_q;
    assign frame_active  = frame_active_q;
    assign frame_done    = frame_done_q;
    assign meas_width    = meas_width_q;
    assign meas_height   = meas_height_q;
    assign err_width     = err_width_q;
    assign err_height    = err_height_q;

`ifdef BAYER_TIMING_CTRL_STATS_EN
    // ------------------------------------------------------------------
    // Statistics: frames closed (wrapping) and bad frames (saturating)
    // ------------------------------------------------------------------
    logic [15:0] frame_count_q;
    logic [15:0] err_count_q;

    // Count closed frames and those closing with any error.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count_q <= 16'd0;
            err_count_q   <= 16'd0;
        end else if (frame_close) begin
            frame_count_q <= frame_count_q + 16'd1;
            if ((close_ew | close_eh) && (err_count_q != 16'hFFFF)) begin
                err_count_q <= err_count_q + 16'd1;
            end
        end
    end

    assign frame_count = frame_count_q;
    assign err_count   = err_count_q;
`endif

endmodule

// File: tb/tb_bayer_timing_ctrl.sv
// Testbench for bayer_timing_ctrl. A driver process generates randomized
// camera timing and pushes expected responses (pixel phases, frame starts,
// frame-close status) into queues from a frame-level reference model; a
// monitor process compares the DUT outputs against those queues each cycle.

module tb_bayer_timing_ctrl;

    localparam int         W    = 16;
    localparam int         H    = 6;
    localparam int         CW   = 5;
    localparam int         MAXC = (1 << CW) - 1;
    localparam int         SKIP = 2;
    localparam logic [1:0] BS   = 2'b01;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_vsync;
    logic          in_hsync;
    logic [1:0]    mode;
    logic          out_vsync;
    logic          out_pix_valid;
    logic          frame_active;
    logic          frame_done;
    logic [CW-1:0] meas_width;
    logic [CW-1:0] meas_height;
    logic          err_width;
    logic          err_height;
`ifdef BAYER_TIMING_CTRL_STATS_EN
    logic [15:0]   frame_count;
    logic [15:0]   err_count;
`endif

    bayer_timing_ctrl #(
        .VIDEO_WIDTH (W),
        .VIDEO_HEIGHT(H),
        .CNT_WIDTH   (CW),
        .BAYER_START (BS),
        .SKIP_FRAMES (SKIP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_vsync     (in_vsync),
        .in_hsync     (in_hsync),
        .mode         (mode),
        .out_vsync    (out_vsync),
        .out_pix_valid(out_pix_valid),
        .frame_active (frame_active),
        .frame_done   (frame_done),
        .meas_width   (meas_width),
        .meas_height  (meas_height),
        .err_width    (err_width),
        .err_height   (err_height)
`ifdef BAYER_TIMING_CTRL_STATS_EN
        ,
        .frame_count  (frame_count),
        .err_count    (err_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Scoreboard queues and counters
    // ------------------------------------------------------------------
    typedef struct {
        int         cyc;
        logic [1:0] mode;
    } pix_exp_t;

    typedef struct {
        int          cyc;
        logic [CW-1:0] w;
        logic [CW-1:0] h;
        logic        ew;
        logic        eh;
    } frm_exp_t;

    pix_exp_t pix_q[$];
    frm_exp_t frm_q[$];
    int       vs_q[$];

    int tests = 0;
    int fails = 0;

    int rst_eff = 1;
    int zlo     = 1;
    int zhi     = 1 << 30;
    bit done_flag = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model (frame level)
    // ------------------------------------------------------------------
    int rise_num;
    int cur_lines;
    int cur_lastw;
    bit cur_errw;
    bit frame_open;
    bit vs_pending;

    function automatic int satc(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic model_reset();
        rise_num   = 0;
        cur_lines  = 0;
        cur_lastw  = 0;
        cur_errw   = 1'b0;
        frame_open = 1'b0;
    endtask

    // A vsync rise driven in the current cycle.
    task automatic model_vs();
        frm_exp_t f;
        rise_num++;
        if (rise_num > SKIP) begin
            vs_q.push_back(cyc + 2);
            if (frame_open) begin
                f.cyc = cyc + 2;
                f.w   = CW'(cur_lastw);
                f.h   = CW'(cur_lines);
                f.ew  = cur_errw;
                f.eh  = (cur_lines != H);
                frm_q.push_back(f);
            end
            frame_open = 1'b1;
        end
        cur_lines = 0;
        cur_errw  = 1'b0;
    endtask

    // Pixel (row r, column c) of the current frame driven this cycle.
    task automatic model_pix(input int r, input int c);
        pix_exp_t p;
        int cc;
        cc = satc(c);
        if (frame_open) begin
            p.cyc     = cyc + 2;
            p.mode[1] = r[0] ^ BS[1];
            p.mode[0] = cc[0] ^ BS[0];
            pix_q.push_back(p);
        end
    endtask

    // A line of len pixels finished (or was cut) this cycle.
    task automatic model_line_end(input int len);
        int l;
        l = satc(len);
        cur_lines = satc(cur_lines + 1);
        cur_lastw = l;
        if (l != W) cur_errw = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int lo, input int hi);
        repeat ($urandom_range(hi, lo)) step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        while (pix_q.size() > 0 && pix_q[$].cyc > cyc) void'(pix_q.pop_back());
        while (frm_q.size() > 0 && frm_q[$].cyc > cyc) void'(frm_q.pop_back());
        while (vs_q.size() > 0 && vs_q[$] > cyc) void'(vs_q.pop_back());
        zhi     = 1 << 30;
        zlo     = cyc + 1;
        rst_eff = cyc + 1;
        repeat (n) begin
            step();
            in_vsync = 1'($urandom);
            in_hsync = 1'($urandom);
        end
        step();
        in_vsync = 1'b0;
        in_hsync = 1'b0;
        step();
        rst = 1'b0;
        zhi = cyc;
        model_reset();
        vs_pending = 1'b0;
    endtask

    task automatic raise_vsync();
        in_vsync = 1'b1;
        model_vs();
        step();
        step();
        in_vsync = 1'b0;
    endtask

    // One frame: vsync rise (unless already issued), then nl lines.
    // bad_line gets bad_len pixels; trunc_line/trunc_px places the next
    // frame's vsync rise on that pixel; close_now raises the next vsync in
    // the same cycle the last line ends.
    task automatic drive_frame(input int nl, input int bad_line, input int bad_len,
                               input int trunc_line, input int trunc_px, input bit close_now);
        if (!vs_pending) raise_vsync();
        vs_pending = 1'b0;
        gap(2, 4);
        for (int r = 0; r < nl; r++) begin
            int len;
            len = (r == bad_line) ? bad_len : W;
            for (int c = 0; c < len; c++) begin
                in_hsync = 1'b1;
                model_pix(r, c);
                if (r == trunc_line && c == trunc_px) begin
                    in_vsync = 1'b1;
                    model_line_end(c);
                    model_vs();
                    step();
                    in_hsync = 1'b0;
                    step();
                    in_vsync = 1'b0;
                    vs_pending = 1'b1;
                    gap(2, 3);
                    return;
                end
                step();
            end
            in_hsync = 1'b0;
            model_line_end(len);
            if (r == nl - 1 && close_now) begin
                raise_vsync();
                vs_pending = 1'b1;
                gap(2, 3);
                return;
            end
            gap(2, 5);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic [CW-1:0] exp_w, exp_h;
    logic          exp_ew, exp_eh, exp_fa;
    logic [15:0]   exp_fc, exp_ec;
    bit            v_now, f_now, p_now;
    frm_exp_t      fe;
    pix_exp_t      pe;

    always @(negedge clk) begin
        if (cyc >= 1 && !done_flag) begin
            if (cyc == rst_eff) begin
                exp_w  = '0;
                exp_h  = '0;
                exp_ew = 1'b0;
                exp_eh = 1'b0;
                exp_fa = 1'b0;
                exp_fc = 16'd0;
                exp_ec = 16'd0;
            end
            if (cyc >= zlo && cyc <= zhi) begin
                check("reset_outputs",
                      32'({mode, out_vsync, out_pix_valid, frame_active, frame_done,
                           meas_width, meas_height, err_width, err_height}), 32'd0);
            end

            v_now = (vs_q.size() > 0 && vs_q[0] == cyc);
            check("out_vsync", 32'(out_vsync), 32'(v_now));
            if (v_now) begin
                void'(vs_q.pop_front());
                exp_fa = 1'b1;
            end
            check("frame_active", 32'(frame_active), 32'(exp_fa));

            f_now = (frm_q.size() > 0 && frm_q[0].cyc == cyc);
            check("frame_done", 32'(frame_done), 32'(f_now));
            if (f_now) begin
                fe     = frm_q.pop_front();
                exp_w  = fe.w;
                exp_h  = fe.h;
                exp_ew = fe.ew;
                exp_eh = fe.eh;
                exp_fc = exp_fc + 16'd1;
                if ((fe.ew || fe.eh) && exp_ec != 16'hFFFF) exp_ec = exp_ec + 16'd1;
            end
            check("meas_width", 32'(meas_width), 32'(exp_w));
            check("meas_height", 32'(meas_height), 32'(exp_h));
            check("err_width", 32'(err_width), 32'(exp_ew));
            check("err_height", 32'(err_height), 32'(exp_eh));
`ifdef BAYER_TIMING_CTRL_STATS_EN
            check("frame_count", 32'(frame_count), 32'(exp_fc));
            check("err_count", 32'(err_count), 32'(exp_ec));
`endif

            p_now = (pix_q.size() > 0 && pix_q[0].cyc == cyc);
            check("out_pix_valid", 32'(out_pix_valid), 32'(p_now));
            if (p_now) begin
                pe = pix_q.pop_front();
                check("mode", 32'(mode), 32'(pe.mode));
            end
        end
    end

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #(10 * 40000);
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        in_vsync   = 1'b0;
        in_hsync   = 1'b0;
        rst        = 1'b1;
        vs_pending = 1'b0;
        model_reset();

        // Reset held with toggling inputs.
        do_reset(3);
        gap(3, 3);

        // Two discarded frames, then the first RUN frame.
        drive_frame(H, -1, 0, -1, -1, 1'b0);
        drive_frame(H, -1, 0, -1, -1, 1'b0);
        drive_frame(H, -1, 0, -1, -1, 1'b0);
        // Clean frame: closes the first RUN frame.
        drive_frame(H, -1, 0, -1, -1, 1'b0);
        // One short line (W-1).
        drive_frame(H, $urandom_range(H - 1, 0), W - 1, -1, -1, 1'b0);
        // Clean frame clears err_width at its close.
        drive_frame(H, -1, 0, -1, -1, 1'b0);
        // vsync rises mid-line: pixel 9 of line 3.
        drive_frame(H, -1, 0, 3, 9, 1'b0);
        // Clean frame whose last line ends with the next vsync rise.
        drive_frame(H, -1, 0, -1, -1, 1'b1);
        // One line long enough to saturate the pixel counter, one extra line.
        drive_frame(H + 1, $urandom_range(H, 0), MAXC + 9, -1, -1, 1'b0);

        // Randomized frames.
        for (int i = 0; i < 4; i++) begin
            int nl;
            int bl;
            nl = $urandom_range(H + 1, H - 1);
            bl = ($urandom_range(1, 0) == 1) ? $urandom_range(nl - 1, 0) : -1;
            drive_frame(nl, bl, $urandom_range(24, 8), -1, -1, 1'b0);
        end

        // Partial frame interrupted by reset mid-line.
        raise_vsync();
        gap(2, 4);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < W; c++) begin
                in_hsync = 1'b1;
                model_pix(r, c);
                step();
            end
            in_hsync = 1'b0;
            model_line_end(W);
            gap(2, 4);
        end
        for (int c = 0; c < 5; c++) begin
            in_hsync = 1'b1;
            model_pix(2, c);
            step();
        end
        do_reset(3);
        gap(2, 4);

        // After reset the skip sequence restarts.
        drive_frame(H, -1, 0, -1, -1, 1'b0);
        drive_frame(H, -1, 0, -1, -1, 1'b0);
        drive_frame(H, -1, 0, -1, -1, 1'b0);
        drive_frame(H, $urandom_range(H - 1, 0), W + 1, -1, -1, 1'b0);
        raise_vsync();
        gap(10, 10);

        check("pix_queue_drained", 32'(pix_q.size()), 32'd0);
        check("frame_queue_drained", 32'(frm_q.size()), 32'd0);
        check("vsync_queue_drained", 32'(vs_q.size()), 32'd0);

        done_flag = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bayer_timing_ctrl.md
Name: bayer_timing_ctrl

Overview:
- Sequencing controller for the OV5640 capture path.
- Watches the raw camera in_vsync/in_hsync and tracks frame, line and pixel position.
- Drives the 2-bit Bayer phase (mode) and the gated frame/pixel-valid strobes used by the line buffer, the 3x3 operator and the CFA stages.
- Drops start-up frames and reports measured resolution and timing errors per frame.

Parameters:
- VIDEO_WIDTH, 1280: expected active pixels per line.
- VIDEO_HEIGHT, 720: expected active lines per frame.
- CNT_WIDTH, 12: width of the pixel and line counters and of the measured-size outputs.
- BAYER_START, 2'b00: Bayer phase of pixel (row 0, col 0). Bit1 is the row phase, bit0 is the column phase.
- SKIP_FRAMES, 2: complete frames discarded after reset before output is enabled. Range 0..15.

Ports:
- clk  input  1  pixel clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_vsync  input  1  raw camera vsync. A rising edge marks a frame boundary.
- in_hsync  input  1  raw camera line-valid. High while pixel data is valid.
- mode  output  2  Bayer phase of the pixel currently flagged by out_pix_valid.
- out_vsync  output  1  one-cycle frame-start pulse, issued in RUN state only.
- out_pix_valid  output  1  registered in_hsync, gated by RUN state.
- frame_active  output  1  high from a RUN-state frame start until that frame's end.
- frame_done  output  1  one-cycle pulse when a RUN frame closes.
- meas_width  output  CNT_WIDTH  pixel count of the last line of the last closed frame.
- meas_height  output  CNT_WIDTH  line count of the last closed frame.
- err_width  output  1  any line of the last closed frame had a length other than VIDEO_WIDTH.
- err_height  output  1  meas_height != VIDEO_HEIGHT.

Behaviour:
- Input stage: in_vsync and in_hsync are registered once (v_d, h_d), with a second copy kept for edge detection.
  - vs_rise = v_d & ~v_d2.
  - hs_fall = ~h_d & h_d2.
- Reset values:
  - All outputs 0.
  - State SYNC, all counters 0, skip counter 0.
- State machine:
  - SYNC: wait for vs_rise, then go to SKIP if SKIP_FRAMES>0, otherwise to RUN.
  - SKIP: each vs_rise increments the skip counter. When the count reaches SKIP_FRAMES, go to RUN on that same vs_rise; that vs_rise counts as the RUN frame start.
  - RUN: stays in RUN until rst.
- RUN outputs:
  - On vs_rise, out_vsync=1 for one cycle and frame_active goes to 1.
  - If frame_active was already 1 on that vs_rise, the previous frame closes in the same cycle:
    - frame_done=1;
    - meas_height, meas_width, err_width and err_height are latched;
    - the line counter is cleared and the sticky width error is cleared.
  - The outputs of a vs_rise appear the cycle after v_d rises, which is 2 clk cycles after in_vsync rises.
- Pixel counter:
  - Increments while h_d=1 and is cleared to 0 on the cycle after hs_fall.
  - On hs_fall the line counter increments, the last-line length is captured, and the sticky width error is set if length != VIDEO_WIDTH.
- Saturation: the pixel and line counters saturate at 2^CNT_WIDTH-1 and do not wrap.
- mode = {line_cnt[0]^BAYER_START[1], pix_cnt[0]^BAYER_START[0]}.
  - It is registered and aligned with out_pix_valid, which is h_d delayed one cycle.
  - Total latency from in_hsync to out_pix_valid/mode is 2 cycles.
  - mode holds its last value while out_pix_valid=0.
- Outside RUN:
  - out_pix_valid, out_vsync, frame_done and frame_active are forced to 0.
  - Counters still run so the first RUN frame starts clean.
- Simultaneous events:
  - vs_rise together with hs_fall: the line is counted into the closing frame before the latch.
  - vs_rise while h_d=1: the line is truncated. Its partial length sets the sticky width error and is counted as a line of the closing frame; the pixel counter restarts at 0.
- Status latching: the err_* and meas_* outputs change only on frame_done and hold otherwise.
- rst asserted mid-frame: everything returns to reset values on the next edge, and the skip sequence restarts.

Optional Feature:
- Macro: BAYER_TIMING_CTRL_STATS_EN.
- When defined, two extra outputs are added:
  - frame_count (16 bit): increments on each frame_done and wraps at 0xFFFF->0.
  - err_count (16 bit): increments on each frame_done where err_width|err_height, and saturates at 0xFFFF.
  - Both are cleared by rst.
- When undefined, these ports and their counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset check (rst held 3 cycles, then in_vsync/in_hsync toggling): all outputs 0 during reset.
  - SKIP_FRAMES=2: no out_vsync or out_pix_valid during the first 2 frames.
  - out_vsync pulses 2 cycles after the 3rd in_vsync rise.
- Nominal 3 frames of 720 lines x 1280 px:
  - frame_done on frames 2 and 3 closing;
  - meas_width=1280, meas_height=720, err_width=err_height=0;
  - out_pix_valid lags in_hsync by exactly 2 cycles.
- Bayer phase with BAYER_START=2'b01:
  - row 0 gives mode sequence 01,00,01,00...;
  - row 1 gives 11,10,11,...;
  - the next frame restarts at 01.
- One 1279-pixel line in a 720-line frame: err_width=1 and err_height=0 at frame_done. The next clean frame clears err_width to 0.
- in_vsync rises mid-line at pixel 500 of line 10:
  - frame_done pulses, meas_height=11, meas_width=500, err_height=1;
  - the new frame's pixel counter starts at 0.
- With BAYER_TIMING_CTRL_STATS_EN defined, after 4 RUN frame closes with one bad frame: frame_count=4 and err_count=1. Assert rst mid-frame: both return to 0 and state returns to SYNC.
